i2c_ov7670_cfg_seq: RTL and testbench
=====================================

// Module: i2c_ov7670_cfg_seq
// PURPOSE
//  Sequencer that configures the OV7670 after reset: waits power-up settle time, issues SCCB soft reset
//  (reg 0x12 = 0x80), then walks the OV7670 config LUT index 0..LUT_SIZE-1 and hands each {reg,data}
//  word to the I2C/SCCB write master. Sits between the config LUT and the I2C master; reports done/error.
// PARAMETERS
//  LUT_SIZE     168        number of LUT entries written (indices 0..LUT_SIZE-1)
//  SLAVE_ADDR   8'h42      OV7670 SCCB write address
//  PWR_DLY_CYC  1_000_000  clk cycles from reset release to first transfer (40 ms @ 25 MHz)
//  RST_DLY_CYC  25_000     clk cycles after soft reset write before LUT walk (1 ms @ 25 MHz)
//  MAX_RETRY    3          NACKed attempts per entry before error
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  cfg_start    in   1   1-cycle pulse: re-run full sequence (accepted only in DONE or ERR)
//  lut_index    out  8   index to config LUT (combinational LUT, data valid same cycle)
//  lut_data     in   16  {reg_addr[15:8], reg_data[7:0]} from LUT
//  i2c_req      out  1   write request, level; held until i2c_done
//  i2c_slave    out  8   slave address, = SLAVE_ADDR
//  i2c_reg      out  8   register address; stable while i2c_req=1
//  i2c_wdata    out  8   register data; stable while i2c_req=1
//  i2c_done     in   1   1-cycle pulse from master: transfer finished
//  i2c_nack     in   1   sampled with i2c_done: 1 = slave did not acknowledge
//  cfg_busy     out  1   sequence in progress
//  cfg_done     out  1   level: all LUT_SIZE entries written OK
//  cfg_err      out  1   level: entry exhausted retries
//  cfg_index    out  8   index of entry currently/last attempted
// BEHAVIOUR
//  Interface: one clock, clk; reset asynchronous active-low, rst_n.
//  Reset values: state=PWR_WAIT, lut_index=0, i2c_req=0, i2c_reg=0, i2c_wdata=0, cfg_busy=1,
//   cfg_done=0, cfg_err=0, cfg_index=0, retry_cnt=0, timer=0. Sequence self-starts on rst_n release.
//  FSM: PWR_WAIT -> SRST_REQ -> SRST_WAIT -> RST_DLY -> FETCH -> REQ -> WAIT -> (FETCH | DONE | ERR)
//   PWR_WAIT: timer counts to PWR_DLY_CYC-1, then SRST_REQ.
//   SRST_REQ: load i2c_reg=0x12, i2c_wdata=0x80, i2c_req=1 -> SRST_WAIT.
//   SRST_WAIT: on i2c_done: req=0; nack -> retry rules below (retry re-enters SRST_REQ); else RST_DLY.
//   RST_DLY: timer counts RST_DLY_CYC cycles, lut_index=0 -> FETCH.
//   FETCH: register lut_data into i2c_reg/i2c_wdata, cfg_index=lut_index -> REQ (1 cycle).
//   REQ: i2c_req=1 -> WAIT. req rises exactly 2 cycles after lut_index changes.
//   WAIT: req held; on i2c_done: req=0 same edge; !nack -> retry_cnt=0, if lut_index==LUT_SIZE-1 DONE
//    else lut_index+1, FETCH. nack -> retry_cnt+1; if retry_cnt+1==MAX_RETRY ERR else REQ (same data).
//   DONE: cfg_busy=0, cfg_done=1. ERR: cfg_busy=0, cfg_err=1, cfg_index frozen at failing entry.
//   DONE/ERR + cfg_start: clear done/err, retry_cnt=0, busy=1 -> PWR_WAIT with timer=0.
//  Boundaries: cfg_start while busy ignored. i2c_done outside SRST_WAIT/WAIT ignored. i2c_done coincident
//   with cfg_start impossible to act on both (start only in DONE/ERR). lut_index never exceeds LUT_SIZE-1.
//   Timers saturate at their terminal value; width = $clog2(PWR_DLY_CYC). rst_n low mid-transfer drops
//   i2c_req asynchronously; master must abort on req fall. Duplicate LUT registers written in order.
// STRUCTURE
//  Shared defs include ov7670_cfg_defs.vh: state encodings, SCCB addr 8'h42, soft-reset pair {8'h12,8'h80},
//   default LUT_SIZE. One sub-module: cfg_delay_timer (load/count/expire, shared by PWR_WAIT and RST_DLY).
//  LUT stays a separate combinational instance; this block owns only sequencing.
// TESTING
//  1 Reset release, master acks all (done 4 cyc after req): first req reg=0x12 data=0x80 at PWR_DLY_CYC+1;
//    then 168 writes, first {0x3a,0x04}, last {0x09,0x00}; cfg_done=1, busy=0, req count=169.
//  2 NACK idx 5 twice then ack: 3 reqs with {0x18,0x04}, idx 6 follows, cfg_done=1, cfg_err=0.
//  3 NACK idx 40 three times: cfg_err=1, cfg_index=40, no further req, cfg_done=0.
//  4 rst_n low while WAIT at idx 100: i2c_req=0 immediately, outputs at reset values; restart from PWR_WAIT.
//  5 cfg_start during busy -> no effect; cfg_start in DONE -> full 169-write sequence repeats.
//  6 Protocol check: i2c_reg/i2c_wdata constant throughout every req-high interval; spurious i2c_done in
//    PWR_WAIT ignored (lut_index stays 0). Use small PWR_DLY_CYC=16, RST_DLY_CYC=8 in sim.

Source files
------------

// File: rtl/i2c_ov7670_cfg_seq_pkg.sv
// Shared definitions for the OV7670 SCCB configuration sequencer: state encoding,
// fixed SCCB constants and the delay-timer width helper.
package i2c_ov7670_cfg_seq_pkg;

  typedef enum logic [3:0] {
    ST_PWR_WAIT  = 4'd0,
    ST_SRST_REQ  = 4'd1,
    ST_SRST_WAIT = 4'd2,
    ST_RST_DLY   = 4'd3,
    ST_FETCH     = 4'd4,
    ST_REQ       = 4'd5,
    ST_WAIT      = 4'd6,
    ST_DONE      = 4'd7,
    ST_ERR       = 4'd8
  } cfg_state_e;

  localparam logic [7:0] OV7670_SCCB_ADDR = 8'h42;
  localparam logic [7:0] SRST_REG         = 8'h12;
  localparam logic [7:0] SRST_DATA        = 8'h80;
  localparam int         DEFAULT_LUT_SIZE = 168;

  // Counter width able to hold cyc-1; never narrower than one bit.
  function automatic int timer_width(input int cyc);
    return (cyc < 2) ? 1 : $clog2(cyc);
  endfunction

endpackage

// File: rtl/i2c_ov7670_cfg_seq_timer.sv
// Delay timer shared by the power-up wait and the post-soft-reset wait.
// Counts while enabled and saturates at the terminal value.
module i2c_ov7670_cfg_seq_timer #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         expired
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expired = (cnt_q == term);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/i2c_ov7670_cfg_seq.sv
// OV7670 configuration sequencer: power-up settle, SCCB soft reset, then one write per
// LUT entry through the I2C/SCCB write master, with bounded retry on NACK.
module i2c_ov7670_cfg_seq
  import i2c_ov7670_cfg_seq_pkg::*;
#(
  parameter int         LUT_SIZE    = DEFAULT_LUT_SIZE,
  parameter logic [7:0] SLAVE_ADDR  = OV7670_SCCB_ADDR,
  parameter int         PWR_DLY_CYC = 1_000_000,
  parameter int         RST_DLY_CYC = 25_000,
  parameter int         MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_start,
  output logic [7:0] lut_index,
  input  logic [15:0] lut_data,
  output logic       i2c_req,
  output logic [7:0] i2c_slave,
  output logic [7:0] i2c_reg,
  output logic [7:0] i2c_wdata,
  input  logic       i2c_done,
  input  logic       i2c_nack,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       cfg_err,
  output logic [7:0] cfg_index,
  output cfg_state_e dbg_state
);

  localparam int              TW          = timer_width(PWR_DLY_CYC);
  localparam int              RW          = $clog2(MAX_RETRY + 1);
  localparam logic [TW-1:0]   PWR_TERM    = TW'(PWR_DLY_CYC - 1);
  localparam logic [TW-1:0]   RST_TERM    = TW'(RST_DLY_CYC - 1);
  localparam logic [7:0]      LAST_IDX    = 8'(LUT_SIZE - 1);
  localparam logic [RW-1:0]   RETRY_LIMIT = RW'(MAX_RETRY);

  // Handshake: i2c_req is a level raised with i2c_reg/i2c_wdata already stable; it
  // stays high (data frozen) until the single-cycle i2c_done, whose i2c_nack is
  // sampled on that same edge, and is dropped on that edge. i2c_done at any other
  // time is ignored.
  cfg_state_e    state_q, state_d;
  logic [7:0]    lut_index_q, lut_index_d;
  logic          req_q, req_d;
  logic [7:0]    reg_q, reg_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    cfg_index_q, cfg_index_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [RW-1:0] retry_inc;

  logic          tmr_clr;
  logic          tmr_en;
  logic [TW-1:0] tmr_term;
  logic          tmr_expired;

  i2c_ov7670_cfg_seq_timer #(
    .W (TW)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .term    (tmr_term),
    .expired (tmr_expired)
  );

  assign tmr_term  = (state_q == ST_RST_DLY) ? RST_TERM : PWR_TERM;
  assign retry_inc = retry_q + RW'(1);

  always_comb begin
    state_d     = state_q;
    lut_index_d = lut_index_q;
    req_d       = req_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    cfg_index_d = cfg_index_q;
    retry_d     = retry_q;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;

    case (state_q)
      ST_PWR_WAIT: begin
        tmr_en = 1'b1;
        if (tmr_expired) begin
          tmr_clr = 1'b1;
          state_d = ST_SRST_REQ;
        end
      end

      ST_SRST_REQ: begin
        reg_d   = SRST_REG;
        wdata_d = SRST_DATA;
        req_d   = 1'b1;
        state_d = ST_SRST_WAIT;
      end

      ST_SRST_WAIT: begin
        if (i2c_done) begin
          req_d = 1'b0;
          if (i2c_nack) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RETRY_LIMIT) ? ST_ERR : ST_SRST_REQ;
          end else begin
            retry_d = '0;
            tmr_clr = 1'b1;
            state_d = ST_RST_DLY;
          end
        end
      end

      ST_RST_DLY: begin
        tmr_en      = 1'b1;
        lut_index_d = '0;
        if (tmr_expired) begin
          tmr_clr = 1'b1;
          state_d = ST_FETCH;
        end
      end

      // The LUT is combinational, so lut_data already reflects lut_index_q here.
      ST_FETCH: begin
        reg_d       = lut_data[15:8];
        wdata_d     = lut_data[7:0];
        cfg_index_d = lut_index_q;
        state_d     = ST_REQ;
      end

      ST_REQ: begin
        req_d   = 1'b1;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (i2c_done) begin
          req_d = 1'b0;
          if (i2c_nack) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RETRY_LIMIT) ? ST_ERR : ST_REQ;
          end else begin
            retry_d = '0;
            if (lut_index_q == LAST_IDX) begin
              state_d = ST_DONE;
            end else begin
              lut_index_d = lut_index_q + 8'd1;
              state_d     = ST_FETCH;
            end
          end
        end
      end

      ST_DONE, ST_ERR: begin
        if (cfg_start) begin
          retry_d     = '0;
          lut_index_d = '0;
          cfg_index_d = '0;
          tmr_clr     = 1'b1;
          state_d     = ST_PWR_WAIT;
        end
      end

      default: begin
        state_d = ST_PWR_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PWR_WAIT;
      lut_index_q <= '0;
      req_q       <= 1'b0;
      reg_q       <= '0;
      wdata_q     <= '0;
      cfg_index_q <= '0;
      retry_q     <= '0;
    end else begin
      state_q     <= state_d;
      lut_index_q <= lut_index_d;
      req_q       <= req_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      cfg_index_q <= cfg_index_d;
      retry_q     <= retry_d;
    end
  end

  assign lut_index = lut_index_q;
  assign i2c_req   = req_q;
  assign i2c_slave = SLAVE_ADDR;
  assign i2c_reg   = reg_q;
  assign i2c_wdata = wdata_q;
  assign cfg_busy  = (state_q != ST_DONE) && (state_q != ST_ERR);
  assign cfg_done  = (state_q == ST_DONE);
  assign cfg_err   = (state_q == ST_ERR);
  assign cfg_index = cfg_index_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_ov7670_cfg_seq.sv
// Bench for i2c_ov7670_cfg_seq: behavioural SCCB master with NACK injection, a LUT
// model, an expected-write queue and a table of configuration scenarios.
module tb_i2c_ov7670_cfg_seq;
  import i2c_ov7670_cfg_seq_pkg::*;

  localparam int LUT_SIZE  = 168;
  localparam int PWR_DLY   = 16;
  localparam int RST_DLY   = 8;
  localparam int MAX_RETRY = 3;
  localparam int NO_NACK   = -2;

  logic        clk;
  logic        rst_n;
  logic        cfg_start;
  logic [7:0]  lut_index;
  logic [15:0] lut_data;
  logic        i2c_req;
  logic [7:0]  i2c_slave;
  logic [7:0]  i2c_reg;
  logic [7:0]  i2c_wdata;
  logic        i2c_done;
  logic        i2c_nack;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_err;
  logic [7:0]  cfg_index;
  logic [3:0]  dbg_state;

  logic        m_done, m_nack, s_done, s_nack;
  assign i2c_done = m_done | s_done;
  assign i2c_nack = m_nack | s_nack;

  logic [15:0] lut_mem [0:255];
  assign lut_data = lut_mem[lut_index];

  i2c_ov7670_cfg_seq #(
    .LUT_SIZE    (LUT_SIZE),
    .SLAVE_ADDR  (8'h42),
    .PWR_DLY_CYC (PWR_DLY),
    .RST_DLY_CYC (RST_DLY),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .lut_index (lut_index),
    .lut_data  (lut_data),
    .i2c_req   (i2c_req),
    .i2c_slave (i2c_slave),
    .i2c_reg   (i2c_reg),
    .i2c_wdata (i2c_wdata),
    .i2c_done  (i2c_done),
    .i2c_nack  (i2c_nack),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .cfg_index (cfg_index),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- SCCB master model ----------------
  int          plan_idx   = NO_NACK;
  int          plan_times = 0;
  int          nack_used, acks, req_count, first_req_cyc, m_cnt;
  logic        m_active;
  logic [15:0] m_word, last_word;

  initial begin
    m_done = 1'b0; m_nack = 1'b0; m_active = 1'b0;
    acks = 0; req_count = 0; nack_used = 0; first_req_cyc = -1; m_cnt = 0;
    m_word = '0; last_word = '0;
    forever begin
      @(negedge clk);
      #1;
      m_done = 1'b0;
      m_nack = 1'b0;
      if (!rst_n || cfg_start) begin
        m_active = 1'b0; acks = 0; req_count = 0; nack_used = 0; first_req_cyc = -1;
      end else if (m_active) begin
        if (!i2c_req) begin
          m_active = 1'b0;
          n_checks++; n_err++;
          $display("FAIL req_dropped: req low before done, word 0x%0h", m_word);
        end else begin
          chk("req_hold", {i2c_reg, i2c_wdata}, m_word);
          m_cnt++;
          if (m_cnt == 3) begin
            m_done   = 1'b1;
            m_active = 1'b0;
            if ((acks - 1) == plan_idx && nack_used < plan_times) begin
              m_nack = 1'b1;
              nack_used++;
            end else begin
              acks++;
              last_word = m_word;
            end
          end
        end
      end else if (i2c_req) begin
        req_count++;
        if (first_req_cyc < 0) first_req_cyc = cyc;
        m_word   = {i2c_reg, i2c_wdata};
        m_active = 1'b1;
        m_cnt    = 0;
        chk("req_slave", {24'd0, i2c_slave}, 32'h42);
        if (exp_q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL unexpected_req: got 0x%0h expected no request", m_word);
        end else begin
          chk("req_word", {16'd0, m_word}, {16'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_plan(input int idx, input int times);
    logic [15:0] w;
    int att;
    for (int e = -1; e < LUT_SIZE; e++) begin
      if (e < 0) w = 16'h1280;
      else       w = lut_mem[e];
      att = (e == idx) ? times + 1 : 1;
      if (att > MAX_RETRY) begin
        repeat (MAX_RETRY) exp_q.push_back(w);
        break;
      end
      repeat (att) exp_q.push_back(w);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"},    {31'd0, i2c_req},  32'd0);
    chk({tag, "_lutidx"}, {24'd0, lut_index}, 32'd0);
    chk({tag, "_reg"},    {24'd0, i2c_reg},   32'd0);
    chk({tag, "_wdata"},  {24'd0, i2c_wdata}, 32'd0);
    chk({tag, "_busy"},   {31'd0, cfg_busy},  32'd1);
    chk({tag, "_done"},   {31'd0, cfg_done},  32'd0);
    chk({tag, "_err"},    {31'd0, cfg_err},   32'd0);
    chk({tag, "_cidx"},   {24'd0, cfg_index}, 32'd0);
    chk({tag, "_state"},  {28'd0, dbg_state}, 32'(ST_PWR_WAIT));
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!cfg_busy) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++; n_err++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles", tag, budget);
    end
  endtask

  typedef struct {
    int         nack_idx;
    int         nack_times;
    bit         pokes;
    logic       exp_done;
    logic       exp_err;
    logic [7:0] exp_index;
    int         exp_reqs;
  } vec_t;

  task automatic start_from_reset(input int idx, input int times);
    @(negedge clk);
    rst_n = 1'b0;
    plan_idx = idx;
    plan_times = times;
    exp_q.delete();
    push_plan(idx, times);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int rc;
    start_from_reset(v.nack_idx, v.nack_times);
    if (v.pokes) begin
      while (cyc < 3) @(negedge clk);
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      s_done = 1'b1;
      s_nack = 1'b1;
      @(negedge clk);
      s_done = 1'b0;
      s_nack = 1'b0;
      @(negedge clk);
      chk({tag, "_spur_lutidx"}, {24'd0, lut_index}, 32'd0);
      chk({tag, "_spur_req"},    {31'd0, i2c_req},   32'd0);
      chk({tag, "_spur_state"},  {28'd0, dbg_state}, 32'(ST_PWR_WAIT));
    end
    wait_idle(tag, 5000);
    chk({tag, "_done"},      {31'd0, cfg_done},  {31'd0, v.exp_done});
    chk({tag, "_err"},       {31'd0, cfg_err},   {31'd0, v.exp_err});
    chk({tag, "_cidx"},      {24'd0, cfg_index}, {24'd0, v.exp_index});
    chk({tag, "_reqs"},      req_count,          v.exp_reqs);
    chk({tag, "_first_req"}, first_req_cyc,      PWR_DLY + 1);
    chk({tag, "_exp_left"},  exp_q.size(),       0);
    if (v.exp_done) chk({tag, "_last_word"}, {16'd0, last_word}, 32'h0900);
    rc = req_count;
    repeat (20) @(negedge clk);
    chk({tag, "_quiet_reqs"}, req_count, rc);
    chk({tag, "_quiet_req"},  {31'd0, i2c_req}, 32'd0);
  endtask

  task automatic restart_check(input string tag);
    int c0;
    plan_idx = NO_NACK;
    plan_times = 0;
    push_plan(NO_NACK, 0);
    @(negedge clk);
    c0 = cyc;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    chk({tag, "_busy"},  {31'd0, cfg_busy},  32'd1);
    chk({tag, "_done0"}, {31'd0, cfg_done},  32'd0);
    chk({tag, "_err0"},  {31'd0, cfg_err},   32'd0);
    wait_idle(tag, 5000);
    chk({tag, "_done"},      {31'd0, cfg_done}, 32'd1);
    chk({tag, "_reqs"},      req_count,         LUT_SIZE + 1);
    chk({tag, "_first_req"}, first_req_cyc,     c0 + PWR_DLY + 2);
    chk({tag, "_exp_left"},  exp_q.size(),      0);
  endtask

  // ---------------- main test ----------------
  vec_t vecs [6];

  initial begin
    bit hit;
    rst_n = 1'b0; cfg_start = 1'b0; s_done = 1'b0; s_nack = 1'b0;
    for (int i = 0; i < 256; i++) lut_mem[i] = {8'(i * 7 + 3), 8'(i * 13)};
    lut_mem[0]   = 16'h3a04;
    lut_mem[5]   = 16'h1804;
    lut_mem[60]  = {lut_mem[59][15:8], 8'h77};
    lut_mem[167] = 16'h0900;

    //          idx      times pokes done err  index reqs
    vecs[0] = '{NO_NACK, 0,    1'b1, 1'b1, 1'b0, 8'd167, 169};
    vecs[1] = '{5,       2,    1'b1, 1'b1, 1'b0, 8'd167, 171};
    vecs[2] = '{40,      3,    1'b0, 1'b0, 1'b1, 8'd40,  44};
    vecs[3] = '{-1,      3,    1'b0, 1'b0, 1'b1, 8'd0,   3};
    vecs[4] = '{167,     2,    1'b0, 1'b1, 1'b0, 8'd167, 171};
    vecs[5] = '{0,       1,    1'b0, 1'b1, 1'b0, 8'd167, 170};

    repeat (3) @(negedge clk);
    check_reset_vals("rst");

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Restart from DONE, then from ERR.
    run_vec(vecs[0], "pre_done");
    restart_check("restart_done");
    run_vec(vecs[2], "pre_err");
    restart_check("restart_err");

    // Reset asserted while entry 100 is in flight.
    start_from_reset(NO_NACK, 0);
    hit = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (acks == 101 && m_active) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      n_checks++; n_err++;
      $display("FAIL midrst_reach: entry 100 not reached, acks %0d expected 101", acks);
    end
    chk("midrst_cidx", {24'd0, cfg_index}, 32'd100);
    chk("midrst_req1", {31'd0, i2c_req},   32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    exp_q.delete();
    run_vec(vecs[0], "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
